// File: rtl/jtag_host.sv
// Host-side JTAG driver: turns parallel RESET/SHIFT_IR/SHIFT_DR/IDLE commands into
// TCK/TMS/TDI sequences starting and ending in Run-Test/Idle, and returns captured TDO.
module jtag_host #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 128,
    parameter int unsigned LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int unsigned CNT_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned DIDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LENP_W = LEN_W + 1;

    localparam logic [1:0] OP_RESET    = 2'd0;
    localparam logic [1:0] OP_SHIFT_IR = 2'd1;
    localparam logic [1:0] OP_SHIFT_DR = 2'd2;
    localparam logic [1:0] OP_IDLE     = 2'd3;

    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_AUTO_RST, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RSP
    } state_t;

    state_t               state, state_d, nst;
    logic [1:0]           op_q, op_d;
    logic [LEN_W-1:0]     len_q, len_d, len_eff;
    logic [MAX_LEN-1:0]   data_q, data_d;
    logic [LEN_W-1:0]     idx, idx_d, nidx;
    logic [LENP_W-1:0]    nidx_w;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 tck_d, tms_d, tdi_d;
    logic                 cmd_ready_d, rsp_valid_d, busy_d;
    logic [MAX_LEN-1:0]   rsp_data_d;

    // Number of TCK bits in the segment a bit-driving state runs
    function automatic logic [LEN_W-1:0] seg_len(input state_t st, input logic [1:0] op,
                                                  input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] n;
        n = '0;
        case (st)
            S_AUTO_RST: n = LEN_W'(6);
            S_PRE: begin
                case (op)
                    OP_RESET:    n = LEN_W'(6);
                    OP_SHIFT_IR: n = LEN_W'(4);
                    OP_SHIFT_DR: n = LEN_W'(3);
                    default:     n = len;
                endcase
            end
            S_SHIFT: n = len;
            S_POST:  n = LEN_W'(2);
            default: n = '0;
        endcase
        return n;
    endfunction

    // TMS value for bit idx of a segment; non-driving states return the idle level 0
    function automatic logic seg_tms(input state_t st, input logic [1:0] op,
                                     input logic [LEN_W-1:0] i, input logic [LEN_W-1:0] len);
        logic t;
        t = 1'b0;
        case (st)
            S_AUTO_RST: t = (i < LEN_W'(5));
            S_PRE: begin
                case (op)
                    OP_RESET:    t = (i < LEN_W'(5));
                    OP_SHIFT_IR: t = (i < LEN_W'(2));
                    OP_SHIFT_DR: t = (i == '0);
                    default:     t = 1'b0;
                endcase
            end
            S_SHIFT: t = (i == len - LEN_W'(1));
            S_POST:  t = (i == '0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_AUTO_RST;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            len_q     <= len_d;
            data_q    <= data_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            tck       <= tck_d;
            tms       <= tms_d;
            tdi       <= tdi_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        idx_d       = idx;
        cnt_d       = cnt;
        tck_d       = tck;
        tms_d       = tms;
        tdi_d       = tdi;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        nst         = state;
        nidx_w      = {1'b0, idx} + LENP_W'(1);
        nidx        = nidx_w[LEN_W-1:0];

        // Shift lengths clamp to 1..MAX_LEN; IDLE counts are taken as-is
        len_eff = cmd_len;
        if (cmd_op != OP_IDLE) begin
            if (cmd_len == '0)
                len_eff = LEN_W'(1);
            else if (cmd_len > LEN_W'(MAX_LEN))
                len_eff = LEN_W'(MAX_LEN);
        end

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    len_d      = len_eff;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    tck_d      = 1'b0;
                    tdi_d      = 1'b0;
                    if (cmd_op == OP_IDLE && cmd_len == '0) begin
                        state_d = S_RSP;
                    end else begin
                        state_d = S_PRE;
                        tms_d   = seg_tms(S_PRE, cmd_op, '0, len_eff);
                    end
                end
            end
            S_AUTO_RST, S_PRE, S_SHIFT, S_POST: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_RISE) begin
                    tck_d = 1'b1;
                    if (state == S_SHIFT)
                        rsp_data_d[idx[DIDX_W-1:0]] = tdo;
                end
                // Falling edge ends the current bit and launches the next one
                if (cnt == CNT_FALL) begin
                    tck_d = 1'b0;
                    cnt_d = '0;
                    if (nidx_w < {1'b0, seg_len(state, op_q, len_q)}) begin
                        idx_d = nidx;
                        nst   = state;
                    end else begin
                        idx_d = '0;
                        case (state)
                            S_AUTO_RST: nst = S_IDLE;
                            S_PRE:      nst = (op_q == OP_SHIFT_IR || op_q == OP_SHIFT_DR) ? S_SHIFT : S_RSP;
                            S_SHIFT:    nst = S_POST;
                            default:    nst = S_RSP;
                        endcase
                    end
                    state_d = nst;
                    tms_d   = seg_tms(nst, op_q, idx_d, len_q);
                    tdi_d   = (nst == S_SHIFT) ? data_q[idx_d[DIDX_W-1:0]] : 1'b0;
                end
            end
            S_RSP: begin
                if (!rsp_valid) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_AUTO_RST;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d == S_AUTO_RST) || (state_d == S_PRE) ||
                      (state_d == S_SHIFT) || (state_d == S_POST);
    end

endmodule
